// File: rtl/doppler_point_generator_if.sv
// Burst request and point output bundle for doppler_point_generator.
// Handshake: a request transfers on a rising clk edge where cfg_valid and cfg_ready are both high;
// cfg_* must be stable while cfg_valid is high. data_valid is a one-cycle strobe with no back-pressure.
interface doppler_point_generator_if #(
    parameter int GAP_W = 8,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [15:0]      cfg_step;
    logic [CNT_W-1:0] cfg_num_points;
    logic [GAP_W-1:0] cfg_gap;
    logic [111:0]     cfg_payload;
    logic             abort;
    logic             data_valid;
    logic [127:0]     clean_point;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid, cfg_step, cfg_num_points, cfg_gap, cfg_payload, abort,
        input  cfg_ready, data_valid, clean_point, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_step, cfg_num_points, cfg_gap, cfg_payload, abort,
        output cfg_ready, data_valid, clean_point, busy, done
    );
endinterface

// File: rtl/doppler_point_generator.sv
// Emits a burst of 128-bit points whose 16-bit phase field advances by a signed step per point,
// with a programmable idle gap between points; stimulus/loopback source for the Doppler chain.
module doppler_point_generator #(
    parameter int PHASE_OFFSET = 0,
    parameter int GAP_W        = 8,
    parameter int CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    doppler_point_generator_if.slave  bus,
    output logic [1:0]                o_dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_idle;
    logic [15:0]      r_step;
    logic [15:0]      r_phase_acc;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_count;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [111:0]     r_payload;
    logic [127:0]     r_clean_point;

    logic             w_accept;
    logic [15:0]      w_step_sel;
    logic [15:0]      w_phase_sel;
    logic [CNT_W-1:0] w_count_sel;
    logic [111:0]     w_payload_sel;

    // Payload bits below PHASE_OFFSET stay in place, the rest move up past the 16-bit phase field.
    function automatic logic [127:0] build_point(input logic [111:0] payload, input logic [15:0] phase);
        logic [127:0] ext;
        logic [127:0] low_mask;
        ext      = {16'b0, payload};
        low_mask = (128'(1) << PHASE_OFFSET) - 128'(1);
        return (ext & low_mask) | ((ext & ~low_mask) << 16) | (128'(phase) << PHASE_OFFSET);
    endfunction

    // r_idle is cleared by reset so cfg_ready only rises one cycle after reset release.
    assign bus.cfg_ready   = r_idle & ~bus.abort;
    assign w_accept        = bus.cfg_valid & bus.cfg_ready;
    assign w_step_sel      = w_accept ? bus.cfg_step    : r_step;
    assign w_phase_sel     = w_accept ? 16'd0           : r_phase_acc;
    assign w_count_sel     = w_accept ? '0              : r_count;
    assign w_payload_sel   = w_accept ? bus.cfg_payload : r_payload;

    assign bus.data_valid  = (r_state == S_EMIT);
    assign bus.busy        = (r_state == S_EMIT) || (r_state == S_GAP);
    assign bus.done        = (r_state == S_DONE);
    assign bus.clean_point = r_clean_point;
    assign o_dbg_state     = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (bus.cfg_num_points == '0) ? S_DONE : S_EMIT;
            S_EMIT: begin
                if (bus.abort)             w_next = S_IDLE;
                else if (r_count == r_num) w_next = S_DONE;
                else if (r_gap == '0)      w_next = S_EMIT;
                else                       w_next = S_GAP;
            end
            S_GAP: begin
                if (bus.abort)                      w_next = S_IDLE;
                else if (r_gap_cnt <= GAP_W'(1))    w_next = S_EMIT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_idle        <= 1'b0;
            r_step        <= '0;
            r_phase_acc   <= '0;
            r_num         <= '0;
            r_count       <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_payload     <= '0;
            r_clean_point <= '0;
        end else begin
            r_state <= w_next;
            r_idle  <= (w_next == S_IDLE);
            if (w_accept) begin
                r_step      <= bus.cfg_step;
                r_num       <= bus.cfg_num_points;
                r_gap       <= bus.cfg_gap;
                r_payload   <= bus.cfg_payload;
                r_phase_acc <= '0;
                r_count     <= '0;
            end
            // The point word is registered on the edge that enters EMIT, so it appears with data_valid.
            if (w_next == S_EMIT) begin
                r_clean_point <= build_point(w_payload_sel, w_phase_sel);
                r_phase_acc   <= w_phase_sel + w_step_sel;
                r_count       <= w_count_sel + CNT_W'(1);
            end
            if (r_state == S_EMIT && w_next == S_GAP)
                r_gap_cnt <= r_gap;
            else if (r_state == S_GAP)
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end
endmodule

// File: tb/tb_doppler_point_generator.sv
// Bench for doppler_point_generator: two instances (phase field at bit 0 and at bit 64) share one stimulus.
module tb_doppler_point_generator;
    localparam int GAP_W = 8;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             cfg_valid = 1'b0;
    logic             abort = 1'b0;
    logic [15:0]      cfg_step = '0;
    logic [CNT_W-1:0] cfg_num = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic [111:0]     cfg_payload = '0;
    logic [1:0]       dbg0;
    logic [1:0]       dbg64;

    doppler_point_generator_if #(.GAP_W(GAP_W), .CNT_W(CNT_W)) if0 ();
    doppler_point_generator_if #(.GAP_W(GAP_W), .CNT_W(CNT_W)) if64 ();

    assign if0.cfg_valid       = cfg_valid;
    assign if0.abort           = abort;
    assign if0.cfg_step        = cfg_step;
    assign if0.cfg_num_points  = cfg_num;
    assign if0.cfg_gap         = cfg_gap;
    assign if0.cfg_payload     = cfg_payload;
    assign if64.cfg_valid      = cfg_valid;
    assign if64.abort          = abort;
    assign if64.cfg_step       = cfg_step;
    assign if64.cfg_num_points = cfg_num;
    assign if64.cfg_gap        = cfg_gap;
    assign if64.cfg_payload    = cfg_payload;

    doppler_point_generator #(.PHASE_OFFSET(0), .GAP_W(GAP_W), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave), .o_dbg_state(dbg0)
    );
    doppler_point_generator #(.PHASE_OFFSET(64), .GAP_W(GAP_W), .CNT_W(CNT_W)) u_dut64 (
        .clk(clk), .reset(reset), .bus(if64.slave), .o_dbg_state(dbg64)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [127:0] exp0_q[$];
    int           exp0_cyc_q[$];
    logic [127:0] exp64_q[$];
    logic [127:0] obs0_q[$];
    int           obs0_cyc_q[$];
    logic [127:0] obs64_q[$];
    int           done_cyc_q[$];
    int           busy_cnt;

    logic [127:0] e_w;
    logic [127:0] o_w;
    int           e_c;
    int           o_c;

    // Reference word built bit by bit from the field layout.
    function automatic logic [127:0] model_point(input int off, input logic [111:0] pl, input logic [15:0] ph);
        logic [127:0] w;
        for (int b = 0; b < 128; b++) begin
            if (b < off)           w[b] = pl[b];
            else if (b < off + 16) w[b] = ph[b - off];
            else                   w[b] = pl[b - 16];
        end
        return w;
    endfunction

    function automatic logic [111:0] rand_payload();
        return {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    endfunction

    task automatic push_burst(input int start, input logic [15:0] step, input int num, input int gap,
                              input logic [111:0] pl);
        logic [31:0] prod;
        for (int k = 0; k < num; k++) begin
            prod = 32'(k) * 32'(step);
            exp0_q.push_back(model_point(0, pl, prod[15:0]));
            exp0_cyc_q.push_back(start + 1 + k * (gap + 1));
            exp64_q.push_back(model_point(64, pl, prod[15:0]));
        end
    endtask

    task automatic clear_sb();
        exp0_q.delete(); exp0_cyc_q.delete(); exp64_q.delete();
        obs0_q.delete(); obs0_cyc_q.delete(); obs64_q.delete(); done_cyc_q.delete();
        busy_cnt = 0;
    endtask

    // Advances n cycles, sampling outputs 1 time unit after each rising edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (if0.data_valid) begin
                obs0_q.push_back(if0.clean_point);
                obs0_cyc_q.push_back(cyc);
            end
            if (if64.data_valid) obs64_q.push_back(if64.clean_point);
            if (if0.done) done_cyc_q.push_back(cyc);
            if (if0.busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        cfg_valid = 1'b1; cfg_num = 8'd3; cfg_step = 16'h0011; cfg_payload = rand_payload();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({if0.data_valid, if0.busy, if0.done, if0.cfg_ready} !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_ctrl got dv/busy/done/ready=%b want 0000",
                     {if0.data_valid, if0.busy, if0.done, if0.cfg_ready});
        end
        n_cmp++;
        if (if0.clean_point !== 128'd0 || if64.clean_point !== 128'd0) begin
            n_mis++;
            $display("FAIL reset_point got %h / %h want 0", if0.clean_point, if64.clean_point);
        end
        n_cmp++;
        if ({if64.data_valid, if64.busy, if64.done, if64.cfg_ready} !== 4'b0000 || dbg0 !== 2'd0) begin
            n_mis++;
            $display("FAIL reset_ctrl64 got %b state %0d want 0000 state 0",
                     {if64.data_valid, if64.busy, if64.done, if64.cfg_ready}, dbg0);
        end
        cfg_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (if0.cfg_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_release_ready got %b want 0", if0.cfg_ready);
        end
        run_cycles(1);
        n_cmp++;
        if (if0.cfg_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_ready_next got %b want 1", if0.cfg_ready);
        end
    endtask

    task automatic test_basic();
        int n0;
        clear_sb();
        n0 = cyc;
        cfg_step = 16'h0100; cfg_num = 8'd4; cfg_gap = 8'd2; cfg_payload = '1; cfg_valid = 1'b1;
        push_burst(n0, cfg_step, 4, 2, cfg_payload);
        n_cmp++;
        if (if0.cfg_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL basic_ready got %b want 1", if0.cfg_ready);
        end
        run_cycles(1);
        cfg_valid = 1'b0;
        run_cycles(13);
        n_cmp++;
        if (obs0_q.size() != exp0_q.size()) begin
            n_mis++;
            $display("FAIL basic_npoints got %0d want %0d", obs0_q.size(), exp0_q.size());
        end
        while (exp0_q.size() > 0 && obs0_q.size() > 0) begin
            e_w = exp0_q.pop_front(); o_w = obs0_q.pop_front();
            e_c = exp0_cyc_q.pop_front(); o_c = obs0_cyc_q.pop_front();
            n_cmp++;
            if (o_w !== e_w || o_c != e_c) begin
                n_mis++;
                $display("FAIL basic_point got %h @%0d want %h @%0d", o_w, o_c - n0, e_w, e_c - n0);
            end
        end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != n0 + 11) begin
            n_mis++;
            $display("FAIL basic_done got %0d pulses first @%0d want 1 @11", done_cyc_q.size(),
                     (done_cyc_q.size() > 0) ? done_cyc_q[0] - n0 : -1);
        end
    endtask

    task automatic test_wrap_back_to_back();
        int n0;
        clear_sb();
        n0 = cyc;
        cfg_step = 16'hC000; cfg_num = 8'd5; cfg_gap = 8'd0; cfg_payload = rand_payload(); cfg_valid = 1'b1;
        push_burst(n0, cfg_step, 5, 0, cfg_payload);
        run_cycles(1);
        cfg_valid = 1'b0;
        run_cycles(9);
        n_cmp++;
        if (obs0_q.size() != exp0_q.size()) begin
            n_mis++;
            $display("FAIL wrap_npoints got %0d want %0d", obs0_q.size(), exp0_q.size());
        end
        while (exp0_q.size() > 0 && obs0_q.size() > 0) begin
            e_w = exp0_q.pop_front(); o_w = obs0_q.pop_front();
            e_c = exp0_cyc_q.pop_front(); o_c = obs0_cyc_q.pop_front();
            n_cmp++;
            if (o_w !== e_w || o_c != e_c) begin
                n_mis++;
                $display("FAIL wrap_point got %h @%0d want %h @%0d", o_w, o_c - n0, e_w, e_c - n0);
            end
        end
        n_cmp++;
        if (busy_cnt != 5) begin
            n_mis++;
            $display("FAIL wrap_busy_cycles got %0d want 5", busy_cnt);
        end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != n0 + 6) begin
            n_mis++;
            $display("FAIL wrap_done got %0d pulses want 1 @6", done_cyc_q.size());
        end
    endtask

    task automatic test_zero_and_ignored();
        int n0;
        logic [111:0] pl;
        clear_sb();
        n0 = cyc;
        cfg_step = 16'h0042; cfg_num = 8'd0; cfg_gap = 8'd1; cfg_payload = rand_payload(); cfg_valid = 1'b1;
        run_cycles(1);
        cfg_valid = 1'b0;
        n_cmp++;
        if (if0.done !== 1'b1 || if0.cfg_ready !== 1'b0 || if0.data_valid !== 1'b0 || if0.busy !== 1'b0) begin
            n_mis++;
            $display("FAIL zero_done_cycle got done/ready/dv/busy=%b want 1000",
                     {if0.done, if0.cfg_ready, if0.data_valid, if0.busy});
        end
        run_cycles(1);
        n_cmp++;
        if (if0.done !== 1'b0 || if0.cfg_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL zero_after got done/ready=%b want 01", {if0.done, if0.cfg_ready});
        end
        n_cmp++;
        if (obs0_q.size() != 0) begin
            n_mis++;
            $display("FAIL zero_no_points got %0d want 0", obs0_q.size());
        end
        clear_sb();
        n0 = cyc;
        pl = rand_payload();
        cfg_step = 16'h0007; cfg_num = 8'd3; cfg_gap = 8'd1; cfg_payload = pl; cfg_valid = 1'b1;
        push_burst(n0, 16'h0007, 3, 1, pl);
        run_cycles(1);
        cfg_step = 16'h5555; cfg_num = 8'd9; cfg_gap = 8'd0; cfg_payload = rand_payload();
        run_cycles(4);
        cfg_valid = 1'b0;
        run_cycles(6);
        n_cmp++;
        if (obs0_q.size() != exp0_q.size()) begin
            n_mis++;
            $display("FAIL ignored_npoints got %0d want %0d", obs0_q.size(), exp0_q.size());
        end
        while (exp0_q.size() > 0 && obs0_q.size() > 0) begin
            e_w = exp0_q.pop_front(); o_w = obs0_q.pop_front();
            e_c = exp0_cyc_q.pop_front(); o_c = obs0_cyc_q.pop_front();
            n_cmp++;
            if (o_w !== e_w || o_c != e_c) begin
                n_mis++;
                $display("FAIL ignored_point got %h @%0d want %h @%0d", o_w, o_c - n0, e_w, e_c - n0);
            end
        end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != n0 + 6) begin
            n_mis++;
            $display("FAIL ignored_done got %0d pulses want 1 @6", done_cyc_q.size());
        end
    endtask

    task automatic test_abort();
        int n0;
        logic [111:0] pl;
        clear_sb();
        n0 = cyc;
        pl = rand_payload();
        cfg_step = 16'h1000; cfg_num = 8'd6; cfg_gap = 8'd3; cfg_payload = pl; cfg_valid = 1'b1;
        push_burst(n0, 16'h1000, 2, 3, pl);
        run_cycles(1);
        cfg_valid = 1'b0;
        run_cycles(5);
        abort = 1'b1;
        run_cycles(1);
        abort = 1'b0;
        #1;
        n_cmp++;
        if (if0.cfg_ready !== 1'b1 || if0.data_valid !== 1'b0 || if0.done !== 1'b0 || dbg0 !== 2'd0) begin
            n_mis++;
            $display("FAIL abort_next got ready/dv/done=%b state %0d want 100 state 0",
                     {if0.cfg_ready, if0.data_valid, if0.done}, dbg0);
        end
        n_cmp++;
        if (if0.clean_point !== model_point(0, pl, 16'h1000)) begin
            n_mis++;
            $display("FAIL abort_hold got %h want %h", if0.clean_point, model_point(0, pl, 16'h1000));
        end
        run_cycles(10);
        n_cmp++;
        if (obs0_q.size() != exp0_q.size() || done_cyc_q.size() != 0) begin
            n_mis++;
            $display("FAIL abort_stop got %0d points %0d dones want 2 points 0 dones",
                     obs0_q.size(), done_cyc_q.size());
        end
        while (exp0_q.size() > 0 && obs0_q.size() > 0) begin
            e_w = exp0_q.pop_front(); o_w = obs0_q.pop_front();
            e_c = exp0_cyc_q.pop_front(); o_c = obs0_cyc_q.pop_front();
            n_cmp++;
            if (o_w !== e_w || o_c != e_c) begin
                n_mis++;
                $display("FAIL abort_point got %h @%0d want %h @%0d", o_w, o_c - n0, e_w, e_c - n0);
            end
        end
        clear_sb();
        abort = 1'b1; cfg_valid = 1'b1; cfg_num = 8'd2; cfg_gap = 8'd0;
        #1;
        n_cmp++;
        if (if0.cfg_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL abort_idle_ready got %b want 0", if0.cfg_ready);
        end
        run_cycles(4);
        abort = 1'b0; cfg_valid = 1'b0;
        n_cmp++;
        if (obs0_q.size() != 0 || busy_cnt != 0 || done_cyc_q.size() != 0) begin
            n_mis++;
            $display("FAIL abort_idle_accept got %0d points %0d busy want 0 0", obs0_q.size(), busy_cnt);
        end
    endtask

    task automatic test_offset_loopback();
        logic [15:0] ph;
        logic [15:0] prev_ph;
        int idx;
        clear_sb();
        cfg_step = 16'h0123; cfg_num = 8'd6; cfg_gap = 8'd1; cfg_payload = rand_payload(); cfg_valid = 1'b1;
        push_burst(cyc, cfg_step, 6, 1, cfg_payload);
        run_cycles(1);
        cfg_valid = 1'b0;
        run_cycles(15);
        n_cmp++;
        if (obs64_q.size() != exp64_q.size()) begin
            n_mis++;
            $display("FAIL offset_npoints got %0d want %0d", obs64_q.size(), exp64_q.size());
        end
        idx = 0;
        prev_ph = '0;
        while (exp64_q.size() > 0 && obs64_q.size() > 0) begin
            e_w = exp64_q.pop_front(); o_w = obs64_q.pop_front();
            n_cmp++;
            if (o_w !== e_w) begin
                n_mis++;
                $display("FAIL offset_point got %h want %h", o_w, e_w);
            end
            ph = o_w[79:64];
            if (idx > 0) begin
                n_cmp++;
                if (16'(ph - prev_ph) !== 16'h0123) begin
                    n_mis++;
                    $display("FAIL offset_phase_diff got %h want 0123", 16'(ph - prev_ph));
                end
            end
            prev_ph = ph;
            idx++;
        end
    endtask

    task automatic test_random();
        int num;
        int gap;
        int n0;
        for (int r = 0; r < 4; r++) begin
            clear_sb();
            n0 = cyc;
            num = $urandom_range(1, 6);
            gap = $urandom_range(0, 3);
            cfg_step = 16'($urandom()); cfg_num = CNT_W'(num); cfg_gap = GAP_W'(gap);
            cfg_payload = rand_payload(); cfg_valid = 1'b1;
            push_burst(n0, cfg_step, num, gap, cfg_payload);
            run_cycles(1);
            cfg_valid = 1'b0;
            run_cycles(num * (gap + 1) + 3);
            n_cmp++;
            if (obs0_q.size() != exp0_q.size() || obs64_q.size() != exp64_q.size()) begin
                n_mis++;
                $display("FAIL rand_npoints got %0d/%0d want %0d", obs0_q.size(), obs64_q.size(), exp0_q.size());
            end
            while (exp0_q.size() > 0 && obs0_q.size() > 0) begin
                e_w = exp0_q.pop_front(); o_w = obs0_q.pop_front();
                e_c = exp0_cyc_q.pop_front(); o_c = obs0_cyc_q.pop_front();
                n_cmp++;
                if (o_w !== e_w || o_c != e_c) begin
                    n_mis++;
                    $display("FAIL rand_point got %h @%0d want %h @%0d", o_w, o_c - n0, e_w, e_c - n0);
                end
            end
            while (exp64_q.size() > 0 && obs64_q.size() > 0) begin
                e_w = exp64_q.pop_front(); o_w = obs64_q.pop_front();
                n_cmp++;
                if (o_w !== e_w) begin
                    n_mis++;
                    $display("FAIL rand_point64 got %h want %h", o_w, e_w);
                end
            end
            n_cmp++;
            if (done_cyc_q.size() != 1 || done_cyc_q[0] != n0 + 1 + num * (gap + 1) - gap) begin
                n_mis++;
                $display("FAIL rand_done got %0d pulses want 1 @%0d", done_cyc_q.size(),
                         1 + num * (gap + 1) - gap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_back_to_back();
        test_zero_and_ignored();
        test_abort();
        test_offset_loopback();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
